// File: rtl/decode_regread_if.sv
// Interface bundling the decode-side input, writeback and execute-side output signals
// of decode_regread_stage. The master modport drives the stage; the slave modport is the stage.
interface decode_regread_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned AW        = 5,
  parameter int unsigned NUM_READ  = 2,
  parameter int unsigned PAYLOAD_W = 64
);
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_pc;
  logic [NUM_READ*AW-1:0]   in_rs_id;
  logic [AW-1:0]            in_rd_id;
  logic [PAYLOAD_W-1:0]     in_payload;
  logic                     flush;
  logic                     wr_en;
  logic [AW-1:0]            wr_id;
  logic [XLEN-1:0]          wr_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_pc;
  logic [NUM_READ*XLEN-1:0] out_rs_data;
  logic [AW-1:0]            out_rd_id;
  logic [PAYLOAD_W-1:0]     out_payload;

  modport master (
    output in_valid, in_pc, in_rs_id, in_rd_id, in_payload, flush,
    output wr_en, wr_id, wr_data, out_ready,
    input  in_ready, out_valid, out_pc, out_rs_data, out_rd_id, out_payload
  );

  modport slave (
    input  in_valid, in_pc, in_rs_id, in_rd_id, in_payload, flush,
    input  wr_en, wr_id, wr_data, out_ready,
    output in_ready, out_valid, out_pc, out_rs_data, out_rd_id, out_payload
  );
endinterface

// File: rtl/decode_regread_stage.sv
// Decode register-read stage: multi-port register file with same-cycle write bypass and a
// one-entry valid/ready output register whose held operands track later writebacks.
module decode_regread_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned AW        = $clog2(NREGS),
  parameter int unsigned NUM_READ  = 2,
  parameter int unsigned PAYLOAD_W = 64,
  parameter bit          ZERO_REG  = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  decode_regread_if.slave bus
);

  logic [XLEN-1:0]          regs_q [NREGS];
  logic [NUM_READ*XLEN-1:0] rd_data;
  logic [NUM_READ*AW-1:0]   held_rs_q;
  logic [NUM_READ*XLEN-1:0] out_rs_data_q;
  logic [31:0]              out_pc_q;
  logic [AW-1:0]            out_rd_id_q;
  logic [PAYLOAD_W-1:0]     out_payload_q;
  logic                     out_valid_q;
  logic                     ready;
  logic                     accept;
  logic                     wr_hit;

  assign ready  = !reset && !bus.flush && (!out_valid_q || bus.out_ready);
  assign accept = bus.in_valid && ready;
  // Writes that actually land in the register file (index 0 is hardwired when ZERO_REG).
  assign wr_hit = bus.wr_en && !(ZERO_REG && (bus.wr_id == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_hit) begin
      regs_q[bus.wr_id] <= bus.wr_data;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_port
    logic [AW-1:0] rs;
    assign rs = bus.in_rs_id[k*AW +: AW];
    assign rd_data[k*XLEN +: XLEN] = (ZERO_REG && (rs == '0))            ? '0 :
                                     (bus.wr_en && (bus.wr_id == rs))    ? bus.wr_data :
                                                                           regs_q[rs];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_rd_id_q   <= '0;
      out_payload_q <= '0;
      out_rs_data_q <= '0;
      held_rs_q     <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q   <= 1'b1;
      out_pc_q      <= bus.in_pc;
      out_rd_id_q   <= bus.in_rd_id;
      out_payload_q <= bus.in_payload;
      out_rs_data_q <= rd_data;
      held_rs_q     <= bus.in_rs_id;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end else if (out_valid_q) begin
      // Stalled instruction must see writebacks that retire while it waits.
      for (int k = 0; k < NUM_READ; k++) begin
        if (wr_hit && (bus.wr_id == held_rs_q[k*AW +: AW])) begin
          out_rs_data_q[k*XLEN +: XLEN] <= bus.wr_data;
        end
      end
    end
  end

  assign bus.in_ready    = ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_rs_data = out_rs_data_q;
  assign bus.out_rd_id   = out_rd_id_q;
  assign bus.out_payload = out_payload_q;

endmodule

// File: tb/tb_decode_regread_stage.sv
// Self-checking bench for decode_regread_stage: a per-cycle vector table on the default
// configuration plus directed sequences for streaming, async reset and a 3-port/64-bit build.
module tb_decode_regread_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_regread_if #(.XLEN(32), .AW(5), .NUM_READ(2), .PAYLOAD_W(64)) bus_a ();
  decode_regread_if #(.XLEN(64), .AW(5), .NUM_READ(3), .PAYLOAD_W(64)) bus_b ();

  decode_regread_stage #(.XLEN(32), .NREGS(32), .NUM_READ(2), .PAYLOAD_W(64), .ZERO_REG(1'b1))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));

  decode_regread_stage #(.XLEN(64), .NREGS(32), .NUM_READ(3), .PAYLOAD_W(64), .ZERO_REG(1'b1))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [63:0] nm;
    logic        iv;
    logic [31:0] pc;
    logic [4:0]  rs0, rs1;
    logic        fl;
    logic        we;
    logic [4:0]  wid;
    logic [31:0] wdat;
    logic        ordy;
    logic        e_rdy;
    logic        e_val;
    logic [31:0] e_pc;
    logic [31:0] e_d0, e_d1;
  } vec_t;

  function automatic vec_t mk(input logic [63:0] nm, input logic iv, input logic [31:0] pc,
                              input logic [4:0] rs0, input logic [4:0] rs1, input logic fl,
                              input logic we, input logic [4:0] wid, input logic [31:0] wdat,
                              input logic ordy, input logic e_rdy, input logic e_val,
                              input logic [31:0] e_pc, input logic [31:0] e_d0,
                              input logic [31:0] e_d1);
    vec_t v;
    v.nm = nm; v.iv = iv; v.pc = pc; v.rs0 = rs0; v.rs1 = rs1; v.fl = fl; v.we = we;
    v.wid = wid; v.wdat = wdat; v.ordy = ordy; v.e_rdy = e_rdy; v.e_val = e_val;
    v.e_pc = e_pc; v.e_d0 = e_d0; v.e_d1 = e_d1;
    return v;
  endfunction

  task automatic drive_a(input logic iv, input logic [31:0] pc, input logic [4:0] rs0,
                         input logic [4:0] rs1, input logic fl, input logic we,
                         input logic [4:0] wid, input logic [31:0] wdat, input logic ordy);
    bus_a.in_valid   = iv;
    bus_a.in_pc      = pc;
    bus_a.in_rs_id   = {rs1, rs0};
    bus_a.in_rd_id   = pc[6:2];
    bus_a.in_payload = {~pc, pc};
    bus_a.flush      = fl;
    bus_a.wr_en      = we;
    bus_a.wr_id      = wid;
    bus_a.wr_data    = wdat;
    bus_a.out_ready  = ordy;
  endtask

  vec_t vecs[15];

  initial begin
    logic [31:0] pc;
    string nm;
    // Table: inputs held for one cycle; e_rdy sampled before the edge, the rest after it.
    vecs[0]  = mk("rd12",  1, 32'h10, 1, 2, 0, 0, 0, 0,            1, 1, 1, 32'h10, 0, 0);
    vecs[1]  = mk("wr5",   0, 32'h0,  0, 0, 0, 1, 5, 32'hDEADBEEF, 1, 1, 0, 0, 0, 0);
    vecs[2]  = mk("rd50",  1, 32'h14, 5, 0, 0, 0, 0, 0,            1, 1, 1, 32'h14, 32'hDEADBEEF, 0);
    vecs[3]  = mk("wr0",   0, 32'h0,  0, 0, 0, 1, 0, 32'h1234,     1, 1, 0, 0, 0, 0);
    vecs[4]  = mk("rd00",  1, 32'h18, 0, 0, 0, 0, 0, 0,            1, 1, 1, 32'h18, 0, 0);
    vecs[5]  = mk("bypass",1, 32'h1C, 7, 7, 0, 1, 7, 32'hA5A5A5A5, 1, 1, 1, 32'h1C, 32'hA5A5A5A5, 32'hA5A5A5A5);
    vecs[6]  = mk("wr3",   0, 32'h0,  0, 0, 0, 1, 3, 32'h1,        1, 1, 0, 0, 0, 0);
    vecs[7]  = mk("wr4",   0, 32'h0,  0, 0, 0, 1, 4, 32'h2,        1, 1, 0, 0, 0, 0);
    vecs[8]  = mk("acc34", 1, 32'h20, 3, 4, 0, 0, 0, 0,            0, 1, 1, 32'h20, 1, 2);
    vecs[9]  = mk("refrsh",1, 32'h24, 1, 1, 0, 1, 4, 32'h99,       0, 0, 1, 32'h20, 1, 32'h99);
    vecs[10] = mk("hold",  0, 32'h0,  0, 0, 0, 1, 9, 32'h55,       0, 0, 1, 32'h20, 1, 32'h99);
    vecs[11] = mk("flush", 1, 32'h28, 3, 3, 1, 0, 0, 0,            0, 0, 0, 0, 0, 0);
    vecs[12] = mk("idle",  0, 32'h0,  0, 0, 0, 0, 0, 0,            1, 1, 0, 0, 0, 0);
    vecs[13] = mk("acc49", 1, 32'h2C, 4, 9, 0, 0, 0, 0,            0, 1, 1, 32'h2C, 32'h99, 32'h55);
    vecs[14] = mk("drnacc",1, 32'h30, 3, 2, 0, 0, 0, 0,            1, 1, 1, 32'h30, 1, 0);

    drive_a(1, 32'h44, 1, 2, 0, 0, 0, 0, 1);
    bus_b.in_valid = 0; bus_b.in_pc = '0; bus_b.in_rs_id = '0; bus_b.in_rd_id = '0;
    bus_b.in_payload = '0; bus_b.flush = 0; bus_b.wr_en = 0; bus_b.wr_id = '0;
    bus_b.wr_data = '0; bus_b.out_ready = 1;
    reset = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus_a.in_ready, 0);
    check("rst_out_valid", bus_a.out_valid, 0);
    check("rst_out_pc", bus_a.out_pc, 0);
    check("rst_out_data", bus_a.out_rs_data, 0);
    check("rst_out_payload", bus_a.out_payload, 0);
    @(negedge clk);
    reset = 1'b0;
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive_a(vecs[i].iv, vecs[i].pc, vecs[i].rs0, vecs[i].rs1, vecs[i].fl, vecs[i].we,
              vecs[i].wid, vecs[i].wdat, vecs[i].ordy);
      nm = $sformatf("%s", vecs[i].nm);
      #1 check({nm, "_in_ready"}, bus_a.in_ready, vecs[i].e_rdy);
      @(posedge clk);
      #1;
      check({nm, "_out_valid"}, bus_a.out_valid, vecs[i].e_val);
      if (vecs[i].e_val) begin
        check({nm, "_out_pc"}, bus_a.out_pc, vecs[i].e_pc);
        check({nm, "_out_rd"}, bus_a.out_rd_id, vecs[i].e_pc[6:2]);
        check({nm, "_out_payload"}, bus_a.out_payload, {~vecs[i].e_pc, vecs[i].e_pc});
        check({nm, "_out_data"}, bus_a.out_rs_data, {vecs[i].e_d1, vecs[i].e_d0});
      end
    end

    // Streaming: one instruction per cycle, no bubbles
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pc = 32'h100 + 32'(i) * 4;
      drive_a(1, pc, 5'(i), 5'(i + 1), 0, 0, 0, 0, 1);
      #1 check($sformatf("stream%0d_in_ready", i), bus_a.in_ready, 1);
      @(posedge clk);
      #1;
      check($sformatf("stream%0d_valid", i), bus_a.out_valid, 1);
      check($sformatf("stream%0d_pc", i), bus_a.out_pc, pc);
    end

    // Async reset while holding drops the instruction and clears the register file
    @(negedge clk);
    drive_a(1, 32'h200, 5, 7, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 check("mid_hold_valid", bus_a.out_valid, 1);
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;
    #1;
    check("async_rst_valid", bus_a.out_valid, 0);
    check("async_rst_pc", bus_a.out_pc, 0);
    check("async_rst_in_ready", bus_a.in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    drive_a(1, 32'h204, 5, 7, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    check("post_rst_valid", bus_a.out_valid, 1);
    check("post_rst_data", bus_a.out_rs_data, 0);
    @(negedge clk);
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // NUM_READ=3, XLEN=64: plain write, then bypass with duplicate indices, then hold refresh
    bus_b.wr_en = 1; bus_b.wr_id = 2; bus_b.wr_data = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    bus_b.wr_id = 7; bus_b.wr_data = 64'hA5A5_A5A5_A5A5_A5A5;
    bus_b.in_valid = 1; bus_b.in_pc = 32'h300; bus_b.in_rs_id = {5'd7, 5'd2, 5'd7};
    bus_b.in_rd_id = 5'd3; bus_b.in_payload = 64'hCAFE; bus_b.out_ready = 0;
    #1 check("b_in_ready", bus_b.in_ready, 1);
    @(posedge clk);
    #1;
    check("b_valid", bus_b.out_valid, 1);
    check("b_pc", bus_b.out_pc, 32'h300);
    check("b_rd", bus_b.out_rd_id, 5'd3);
    check("b_payload", bus_b.out_payload, 64'hCAFE);
    check("b_bypass_data", bus_b.out_rs_data,
          {64'hA5A5_A5A5_A5A5_A5A5, 64'h0123_4567_89AB_CDEF, 64'hA5A5_A5A5_A5A5_A5A5});
    @(negedge clk);
    bus_b.in_valid = 0; bus_b.wr_en = 1; bus_b.wr_id = 2; bus_b.wr_data = 64'hFFFF_0000_FFFF_0000;
    #1 check("b_hold_in_ready", bus_b.in_ready, 0);
    @(posedge clk);
    #1 check("b_refresh_data", bus_b.out_rs_data,
             {64'hA5A5_A5A5_A5A5_A5A5, 64'hFFFF_0000_FFFF_0000, 64'hA5A5_A5A5_A5A5_A5A5});
    @(negedge clk);
    bus_b.wr_en = 0; bus_b.out_ready = 1;
    @(posedge clk);
    #1 check("b_drain_valid", bus_b.out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
